count_capture_fifo: RTL and testbench
=====================================

// Module: count_capture_fifo
// PURPOSE
//   Downstream consumer of the 8-bit free-running counter. Timestamps events with the live counter value
//   and queues them for a slower reader. Events: rising edge of trig; counter decrease (wrap or reset).
//   Entries are drained through a valid/ready interface. Events arriving when the queue is full are dropped
//   and flagged in a sticky bit.
// PARAMETERS
//   WIDTH      8   counter value width, bits
//   DEPTH      8   queue entries; power of 2, >= 2
//   AUTO_WRAP  1   1 = log counter decreases as events; 0 = trig events only
// PORTS
//   clk        in   1            single clock; all state updates on posedge
//   reset      in   1            asynchronous, active-high; clears all state immediately
//   value      in   WIDTH        live counter value, synchronous to clk
//   trig       in   1            capture request, level; sampled on clk
//   clr_ovf    in   1            clear sticky overflow flag
//   out_data   out  WIDTH+1      {src, captured value}; src 0 = trig, 1 = wrap
//   out_valid  out  1            queue non-empty
//   out_ready  in   1            reader accepts head entry when out_valid & out_ready
//   level      out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//   overflow   out  1            sticky: an event was dropped
// BEHAVIOUR
//   - Reset values: out_valid=0, level=0, overflow=0, out_data=0. Pointers=0, trig_q=0, val_q=0, primed=0.
//   - Reset mid-operation discards all queued entries; there is no partial state.
//   - Edge detect: trig_ev = trig & ~trig_q; trig_q <= trig every cycle. A held-high trig gives one event.
//   - Wrap detect: wrap_ev = AUTO_WRAP & primed & (value < val_q). val_q <= value and primed <= 1 every cycle.
//     The first cycle after reset never produces a wrap event.
//   - At most one event per cycle. If trig_ev & wrap_ev coincide, one entry {0,value} is written (trig wins).
//   - The captured value is the value present in the same cycle the event is detected.
//   - Latency: an event in cycle N with an empty queue makes out_valid=1 and out_data valid in cycle N+1.
//   - The queue is first-word fall-through: out_data = head entry whenever out_valid=1.
//     out_data is undefined-free (holds last head) when out_valid=0.
//   - pop = out_valid & out_ready. push = event & (~full | pop).
//   - Full and pop in the same cycle: the push is accepted, level is unchanged.
//   - Empty and push in the same cycle: the entry is written; out_valid rises next cycle.
//     There is no same-cycle bypass.
//   - Full with no pop and an event: the event is dropped, overflow <= 1, queue contents are unchanged.
//   - overflow: a set term beats clr_ovf in the same cycle. clr_ovf alone clears it the next cycle.
//   - Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
//     Full/empty are derived from level (width $clog2(DEPTH)+1).
//   - out_ready while out_valid=0 is ignored. level never underflows or exceeds DEPTH.
// STRUCTURE
//   - Shared package cnt_pkg: SRC_TRIG=1'b0, SRC_WRAP=1'b1, CNT_WIDTH=8 (default WIDTH).
//   - Sub-module sync_fifo (WIDTH, DEPTH): storage, pointers, level, FWFT output, push/pop handling.
//     Reused elsewhere.
//   - Top level: trig edge detect, wrap compare, event mux/priority, overflow flag, sync_fifo instance.
// TESTING
//   1. Reset pulse mid-run with 3 entries queued -> out_valid=0, level=0, overflow=0 during reset and after.
//   2. trig high for 5 cycles starting when value=8'h12, out_ready=0 -> exactly one entry {0,8'h12};
//      level=1 next cycle.
//   3. value steps 8'hFE, 8'hFF, 8'h00 -> one entry {1,8'h00}. Counter reset 8'h2A->8'h00 -> entry {1,8'h00}.
//      Same with AUTO_WRAP=0 -> no entries.
//   4. trig edge in the same cycle as an FF->00 wrap -> a single entry {0,8'h00}; level increments by 1.
//   5. out_ready=0, 9 trig edges at values 1..9 (DEPTH=8) -> level=8, overflow=1.
//      Drain yields 1..8 in order. clr_ovf -> overflow=0.
//   6. Full queue, trig edge with out_ready=1 in the same cycle -> head popped, new entry accepted,
//      level stays 8, overflow stays 0.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared definitions for consumers of the free-running counter.
package cnt_pkg;
  localparam int CNT_WIDTH = 8;

  typedef enum logic {
    SRC_TRIG = 1'b0,
    SRC_WRAP = 1'b1
  } src_e;
endpackage

// File: rtl/count_capture_fifo_if.sv
// Sample/drain bus of the capture queue: counter and trigger in, FWFT entries out.
interface count_capture_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  logic [WIDTH-1:0]        value;
  logic                    trig;
  logic                    clr_ovf;
  logic [WIDTH:0]          out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [$clog2(DEPTH):0]  level;
  logic                    overflow;

  modport slave (
    input  value, trig, clr_ovf, out_ready,
    output out_data, out_valid, level, overflow
  );

  modport master (
    output value, trig, clr_ovf, out_ready,
    input  out_data, out_valid, level, overflow
  );
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; head is registered so the output is clean while empty.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [LW-1:0]    level_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             pop_ok, push_ok;

  assign valid_o = (level_q != '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign pop_ok  = pop_i & valid_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
    head_d   = head_q;
    // When nothing old survives the pop, the new head is the entry being written.
    if (level_d != '0)
      head_d = (level_q == LW'(pop_ok)) ? din_i : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign dout_o  = head_q;
  assign level_o = level_q;
endmodule

// File: rtl/count_capture_fifo.sv
// Timestamps trig rising edges and counter decreases with the live count and queues them.
module count_capture_fifo
  import cnt_pkg::*;
#(
  parameter int WIDTH     = CNT_WIDTH,
  parameter int DEPTH     = 8,
  parameter bit AUTO_WRAP = 1'b1
) (
  input  logic clk,
  input  logic reset,
  count_capture_fifo_if.slave bus
);
  logic             trig_q, trig_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             primed_q, primed_d;
  logic             ovf_q, ovf_d;

  logic             trig_ev, wrap_ev, ev, push, pop, full, valid;
  src_e             src;
  logic [WIDTH:0]   entry;

  assign trig_ev = bus.trig & ~trig_q;
  assign wrap_ev = AUTO_WRAP & primed_q & (bus.value < val_q);
  assign ev      = trig_ev | wrap_ev;
  // A coincident trig edge claims the single slot for this cycle.
  assign src     = trig_ev ? SRC_TRIG : SRC_WRAP;
  assign entry   = {src, bus.value};
  assign pop     = valid & bus.out_ready;
  assign push    = ev & (~full | pop);

  always_comb begin
    trig_d   = bus.trig;
    val_d    = bus.value;
    primed_d = 1'b1;
    ovf_d    = ovf_q;
    if (ev & full & ~pop) ovf_d = 1'b1;
    else if (bus.clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_q   <= 1'b0;
      val_q    <= '0;
      primed_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      trig_q   <= trig_d;
      val_q    <= val_d;
      primed_q <= primed_d;
      ovf_q    <= ovf_d;
    end
  end

  sync_fifo #(.WIDTH(WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (entry),
    .pop_i   (pop),
    .dout_o  (bus.out_data),
    .valid_o (valid),
    .full_o  (full),
    .level_o (bus.level)
  );

  assign bus.out_valid = valid;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_count_capture_fifo.sv
// Random and directed stimulus against a queue-level reference model with a scoreboard monitor.
module tb_count_capture_fifo;
  localparam int W = 8;
  localparam int D = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  initial forever #5 clk = ~clk;

  count_capture_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();
  count_capture_fifo_if #(.WIDTH(W), .DEPTH(D)) bus_nw ();

  count_capture_fifo #(.WIDTH(W), .DEPTH(D), .AUTO_WRAP(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  // Trig-less, never-drained twin with wrap logging off: it must stay empty.
  count_capture_fifo #(.WIDTH(W), .DEPTH(D), .AUTO_WRAP(1'b0)) dut_nw (
    .clk(clk), .reset(reset), .bus(bus_nw));

  assign bus_nw.value     = bus.value;
  assign bus_nw.trig      = 1'b0;
  assign bus_nw.clr_ovf   = 1'b0;
  assign bus_nw.out_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: occupancy count, sticky drop flag, expected entries in order.
  logic [W:0]   sb[$];
  int           m_lvl = 0;
  bit           m_ovf = 1'b0;
  logic         m_tq = 1'b0;
  logic [W-1:0] m_vq = '0;
  bit           m_pr = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lvl = 0; m_ovf = 1'b0; m_tq = 1'b0; m_vq = '0; m_pr = 1'b0;
      sb.delete();
    end else begin
      bit tev, wev, pop, drop;
      tev  = bus.trig && !m_tq;
      wev  = m_pr && (bus.value < m_vq);
      pop  = (m_lvl > 0) && bus.out_ready;
      drop = 1'b0;
      if (tev || wev) begin
        if (m_lvl < D || pop) begin
          sb.push_back({tev ? 1'b0 : 1'b1, bus.value});
          m_lvl++;
        end else drop = 1'b1;
      end
      if (pop) m_lvl--;
      if (drop) m_ovf = 1'b1;
      else if (bus.clr_ovf) m_ovf = 1'b0;
      m_tq = bus.trig; m_vq = bus.value; m_pr = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("level", 32'(bus.level), 32'(m_lvl));
    chk("out_valid", 32'(bus.out_valid), 32'(m_lvl != 0));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("nowrap_level", 32'(bus_nw.level), 32'd0);
    if (bus.out_valid && sb.size() > 0) begin
      chk("head", 32'(bus.out_data), 32'(sb[0]));
      if (bus.out_ready) void'(sb.pop_front());
    end
  end

  task automatic cyc(input logic [W-1:0] v, input logic t, input logic rdy, input logic clr);
    bus.value = v; bus.trig = t; bus.out_ready = rdy; bus.clr_ovf = clr;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [W-1:0] v;
    bus.value = '0; bus.trig = 1'b0; bus.out_ready = 1'b0; bus.clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Three entries queued, then an asynchronous mid-cycle reset.
    for (int i = 0; i < 3; i++) begin cyc(8'h05, 1, 0, 0); cyc(8'h05, 0, 0, 0); end
    @(negedge clk);
    chk("t1_level3", 32'(bus.level), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("t1_async_level", 32'(bus.level), 32'd0);
    chk("t1_async_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t1_post_level", 32'(bus.level), 32'd0);
    chk("t1_post_ovf", 32'(bus.overflow), 32'd0);
    @(posedge clk); #1;

    // Held trig gives one event.
    repeat (5) cyc(8'h12, 1, 0, 0);
    cyc(8'h12, 0, 0, 0);
    @(negedge clk);
    chk("t2_level", 32'(bus.level), 32'd1);
    chk("t2_data", 32'(bus.out_data), 32'h012);
    @(posedge clk); #1;
    cyc(8'h12, 0, 1, 0);

    // Natural wrap, then counter reset.
    cyc(8'hFE, 0, 0, 0); cyc(8'hFF, 0, 0, 0); cyc(8'h00, 0, 0, 0); cyc(8'h00, 0, 0, 0);
    @(negedge clk);
    chk("t3_wrap_level", 32'(bus.level), 32'd1);
    chk("t3_wrap_data", 32'(bus.out_data), 32'h100);
    @(posedge clk); #1;
    cyc(8'h2A, 0, 0, 0); cyc(8'h00, 0, 0, 0); cyc(8'h00, 0, 0, 0);
    @(negedge clk);
    chk("t3_rst_level", 32'(bus.level), 32'd2);
    @(posedge clk); #1;
    cyc(8'h00, 0, 1, 0); cyc(8'h00, 0, 1, 0);

    // Trig edge coincident with FF->00 wrap.
    cyc(8'hFF, 0, 0, 0); cyc(8'h00, 1, 0, 0); cyc(8'h00, 0, 0, 0);
    @(negedge clk);
    chk("t4_level", 32'(bus.level), 32'd1);
    chk("t4_data", 32'(bus.out_data), 32'h000);
    @(posedge clk); #1;
    cyc(8'h00, 0, 1, 0);

    // Nine edges into an eight-deep queue.
    for (int i = 1; i <= 9; i++) begin cyc(8'(i), 1, 0, 0); cyc(8'(i), 0, 0, 0); end
    @(negedge clk);
    chk("t5_full_level", 32'(bus.level), 32'd8);
    chk("t5_overflow", 32'(bus.overflow), 32'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("t5_drain", 32'(bus.out_data), 32'(i));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    cyc(8'h09, 0, 0, 1);
    @(negedge clk);
    chk("t5_clr", 32'(bus.overflow), 32'd0);
    @(posedge clk); #1;

    // Full queue: push and pop in the same cycle.
    for (int i = 10; i <= 17; i++) begin cyc(8'(i), 1, 0, 0); cyc(8'(i), 0, 0, 0); end
    cyc(8'd18, 1, 1, 0);
    cyc(8'd18, 0, 0, 0);
    @(negedge clk);
    chk("t6_level", 32'(bus.level), 32'd8);
    chk("t6_ovf", 32'(bus.overflow), 32'd0);
    chk("t6_head", 32'(bus.out_data), 32'd11);
    @(posedge clk); #1;
    repeat (9) cyc(8'd18, 0, 1, 0);

    // Random traffic with bursts of back-pressure and occasional resets.
    v = 8'd18;
    for (int n = 0; n < 3000; n++) begin
      bit slow;
      slow = ((n / 200) % 2) == 1;
      if ($urandom_range(15) == 0) v = 8'($urandom);
      else v = v + 8'd1;
      if ($urandom_range(499) == 0) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
      end
      cyc(v, $urandom_range(3) == 0,
          slow ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0),
          $urandom_range(15) == 0);
    end
    cyc(v, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
